clp_axil_regs: RTL
==================

# clp_axil_regs

AXI4-Lite responder (slave) register file for the PMOD CLP character-LCD peripheral. It terminates the S00_AXI register bus, holds the software-visible control/data registers, and presents them, plus per-register write pulses, to the LCD controller logic. Bus behaviour matches what the S00_AXI master drives: single-beat writes with an OKAY response, and read-back of the value last written.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; NUM_REGS = 2**(C_S_AXI_ADDR_WIDTH-2) = 4.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg_q  out  NUM_REGS*32  register contents, reg n at bits [32n+31:32n].
- reg_wr  out  NUM_REGS  one-cycle pulse, bit n high the cycle after reg n is updated.

## Operation
- Register index = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored. All registers read/write, reset to 0.
- Write path: AW and W captured independently into one-entry holding buffers (aw_full, w_full). AWREADY = !aw_full & !BVALID & !S_AXI_ARESET; WREADY = !w_full & !BVALID & !S_AXI_ARESET. AW and W may arrive in either order, same cycle, or any number of cycles apart.
- Commit: the first clock edge at which both address and data are available (held or handshaking that cycle) updates the register byte-wise: byte k written iff WSTRB[k]; buffers clear; BVALID set; reg_wr[n] set for one cycle. WSTRB=0 still commits and responds; reg_wr still pulses.
- BVALID holds until BREADY; no new AW/W accepted while BVALID high (one outstanding write).
- Read path: ARREADY = !RVALID & !S_AXI_ARESET. On AR handshake, RDATA loaded from the addressed register and RVALID set on that edge; RDATA and RVALID stable until RREADY handshake.
- Read and write are independent. Read sampling same edge as a commit to the same register returns the pre-write value.
- States: write FSM IDLE (buffers empty) -> PARTIAL (one buffer full) -> RESP (BVALID) -> IDLE on BREADY; IDLE -> RESP directly on simultaneous AW+W. Read FSM IDLE -> RDATA -> IDLE on RREADY.

## Timing
- Reset (asynchronous assert, synchronous release at S_AXI_ACLK): all ready/valid outputs 0, BRESP/RRESP 0, RDATA 0, reg_q 0, reg_wr 0, buffers empty. Reset during any transaction abandons it; no response is issued.
- Write latency: BVALID the cycle after the last of AW/W handshakes; register visible on reg_q on the same edge.
- Read latency: RVALID one cycle after AR handshake.
- Back-to-back: with BREADY/RREADY held high, one write per 2 cycles, one read per 2 cycles.

## Structure
- Shared package clp_axil_pkg: RESP_OKAY constant, NUM_REGS derivation, byte-merge function (old, new, strobe).
- Single module; no sub-module needed.

## Test plan
- Reset then write 0x0101FFFF to 0x0, read 0x0 -> RDATA 0x0101FFFF, BRESP/RRESP 00, reg_wr 0001 pulse for one cycle.
- Write/read-back 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x4, 0x8, 0xC -> each reads back exactly; reg0 unchanged at 0x0101FFFF.
- AW at cycle 0, W at cycle 3 (and reversed order) -> single commit, BVALID one cycle after the W handshake, value correct.
- reg1 = 0xabcd0001, write 0x12345678 with WSTRB 0011 -> reads 0xabcd5678; WSTRB 0000 -> unchanged, BVALID still asserted.
- Hold BREADY low 5 cycles with next AW/W presented -> AWREADY/WREADY stay 0 until the B handshake, then the second write completes.
- Assert S_AXI_ARESET with RVALID pending and AW captured -> RVALID, BVALID, all readies 0 and reg_q 0 immediately; next write/read after release is correct.

Source files
------------

// File: rtl/clp_axil_pkg.sv
// Shared definitions for the PMOD CLP AXI4-Lite register file: response codes,
// register-count derivation, byte-lane merge and FSM state encodings.
package clp_axil_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int unsigned num_regs(input int unsigned addr_w);
    return 32'd1 << (addr_w - 32'd2);
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_PARTIAL = 2'd1,
    WR_RESP    = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/clp_axil_regs.sv
// AXI4-Lite register file for the PMOD CLP LCD peripheral: independent AW/W capture,
// one outstanding write and one outstanding read, registers exported with write pulses.
module clp_axil_regs
  import clp_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  localparam int NUM_REGS = int'(num_regs(C_S_AXI_ADDR_WIDTH))
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  // Handshake rule on every channel: a beat transfers on a rising edge where
  // VALID and READY are both high; a VALID, once raised, holds until that edge.

  wr_state_e            wr_state_q, wr_state_d;
  rd_state_e            rd_state_q, rd_state_d;
  logic                 aw_full_q, aw_full_d;
  logic [IDX_W-1:0]     awaddr_q, awaddr_d;
  logic                 w_full_q, w_full_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [NUM_REGS-1:0]  reg_wr_q, reg_wr_d;
  logic [31:0]          regs_q [NUM_REGS];
  logic [31:0]          regs_d [NUM_REGS];

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]     wr_idx, ar_idx;
  logic [31:0]          wr_data;
  logic [3:0]           wr_strb;
  logic                 unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_full_q && (wr_state_q != WR_RESP) && !S_AXI_ARESET;
  assign S_AXI_WREADY  = !w_full_q  && (wr_state_q != WR_RESP) && !S_AXI_ARESET;
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = (rd_state_q == RD_IDLE) && !S_AXI_ARESET;
  assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr        = reg_wr_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Held buffer wins over the live bus; only one of them can be valid at a time.
  assign wr_idx  = aw_full_q ? awaddr_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_full_q  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb = w_full_q  ? wstrb_q  : S_AXI_WSTRB;
  assign commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (commit) begin
      regs_d[wr_idx]   = byte_merge(regs_q[wr_idx], wr_data, wr_strb);
      reg_wr_d[wr_idx] = 1'b1;
      aw_full_d        = 1'b0;
      w_full_d         = 1'b0;
    end

    if (commit)
      wr_state_d = WR_RESP;
    else if (wr_state_q == WR_RESP && !S_AXI_BREADY)
      wr_state_d = WR_RESP;
    else if (aw_full_d || w_full_d)
      wr_state_d = WR_PARTIAL;
    else
      wr_state_d = WR_IDLE;

    // Reads sample the pre-commit contents when both land on the same edge.
    rd_state_d = rd_state_q;
    if (ar_hs) begin
      rd_state_d = RD_DATA;
      rdata_d    = regs_q[ar_idx];
    end else if (rd_state_q == RD_DATA && S_AXI_RREADY) begin
      rd_state_d = RD_IDLE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_full_q  <= 1'b0;
      awaddr_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      reg_wr_q   <= '0;
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_full_q  <= aw_full_d;
      awaddr_q   <= awaddr_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      reg_wr_q   <= reg_wr_d;
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= regs_d[n];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int n = 0; n < NUM_REGS; n++) reg_q[32*n +: 32] = regs_q[n];
  end

endmodule
